// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// lzb_blank() backs the optional SEVEN_SEG_LZB_EN leading-zero blanking.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int         ANODE_W    = 2;
  localparam int         DIGIT_W    = 4;
  localparam int         DATA_W     = 16;
  localparam logic [1:0] DIGIT_LAST = 2'd3;

  // True when the selected digit and every digit above it are zero.
  // Digit 0 always stays lit.
  function automatic logic lzb_blank(input logic [DATA_W-1:0] d,
                                     input logic [ANODE_W-1:0] sel);
    logic z;
    case (sel)
      2'd3:    z = (d[15:12] == 4'h0);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd1:    z = (d[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Digit scan FSM and counter: alternates a blanking gap and a lit period per
// digit, steps the anode select and flags each frame boundary.
module seven_seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  output logic [ANODE_W-1:0] o_anode_sel,
  output logic               o_blank,
  output logic               o_frame_done,
  output logic               o_frame_tick
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIGIT_LAST_CNT = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST_CNT = CNT_W'(BLANK_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ANODE_W-1:0] r_anode, w_anode_nxt;
  logic               r_blank, w_blank_nxt;
  logic               r_frame_done;
  logic               w_frame_tick;

  // Next-state, counter and anode stepping.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_anode_nxt  = r_anode;
    w_blank_nxt  = r_blank;
    w_frame_tick = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_LAST_CNT) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
          w_blank_nxt = 1'b0;
        end else begin
          w_blank_nxt = 1'b1;
        end
      end
      SHOW: begin
        if (r_cnt == DIGIT_LAST_CNT) begin
          w_state_nxt  = BLANK;
          w_cnt_nxt    = '0;
          w_anode_nxt  = r_anode + ANODE_W'(1);
          w_blank_nxt  = 1'b1;
          w_frame_tick = (r_anode == DIGIT_LAST);
        end else begin
          w_blank_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_blank_nxt = 1'b1;
      end
    endcase
  end

  // Scan state registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_anode      <= '0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_anode      <= w_anode_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_frame_tick;
    end
  end

  assign o_anode_sel  = r_anode;
  assign o_blank      = r_blank;
  assign o_frame_done = r_frame_done;
  assign o_frame_tick = w_frame_tick;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller: load handshake, frame-aligned commit and scan.
// Define SEVEN_SEG_LZB_EN to blank leading zero digits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_valid,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic [ANODE_W-1:0] anode_sel,
  output logic               blank,
  output logic               frame_done
);

  logic [ANODE_W-1:0] w_anode_sel;
  logic               w_base_blank;
  logic               w_frame_done;
  logic               w_frame_tick;
  logic               w_transfer;
  logic               w_commit;

  logic               r_pending;
  logic [DATA_W-1:0]  r_pending_data;
  logic               r_load_ready;
  logic [DATA_W-1:0]  r_data_out;

  seven_seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .o_anode_sel  (w_anode_sel),
    .o_blank      (w_base_blank),
    .o_frame_done (w_frame_done),
    .o_frame_tick (w_frame_tick)
  );

  assign w_transfer = load_valid & r_load_ready;
  assign w_commit   = w_frame_tick & r_pending;

  // Pending buffer; a transfer needs load_ready, which is low whenever pending is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending      <= 1'b0;
      r_pending_data <= '0;
    end else if (w_transfer) begin
      r_pending      <= 1'b1;
      r_pending_data <= load_data;
    end else if (w_commit) begin
      r_pending      <= 1'b0;
    end else begin
      r_pending      <= r_pending;
    end
  end

  // Ready drops right after acceptance, rises one cycle after commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_ready <= 1'b1;
    end else if (w_transfer) begin
      r_load_ready <= 1'b0;
    end else begin
      r_load_ready <= ~r_pending;
    end
  end

  // Displayed value only changes on the frame boundary edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (w_commit) begin
      r_data_out <= r_pending_data;
    end else begin
      r_data_out <= r_data_out;
    end
  end

  assign load_ready = r_load_ready;
  assign data_out   = r_data_out;
  assign anode_sel  = w_anode_sel;
  assign frame_done = w_frame_done;

`ifdef SEVEN_SEG_LZB_EN
  assign blank = w_base_blank | lzb_blank(r_data_out, w_anode_sel);
`else
  assign blank = w_base_blank;
`endif

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (DIGIT_CYCLES=8, BLANK_CYCLES=2).
module tb_seven_seg_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int SLOT = DC + BC;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [15:0] data_out;
  logic [1:0]  anode_sel;
  logic        blank;
  logic        frame_done;

  int          n_cmp;
  int          n_bad;
  int          k;
  logic [15:0] exp_data;

  seven_seg_scan_ctrl #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .data_out   (data_out),
    .anode_sel  (anode_sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic exp_blank(input int kk, input logic [15:0] d);
    int ph;
    int an;
    ph = kk % SLOT;
    an = (kk / SLOT) % 4;
    if (ph < BC) return 1'b1;
    if (LZB && an != 0 && ((d >> (4 * an)) == 16'h0)) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock, then check scan outputs against the cycle-index model.
  task automatic step_chk();
    @(posedge clk);
    @(negedge clk);
    k++;
    check_eq("anode_sel", anode_sel, (k / SLOT) % 4);
    check_eq("blank", blank, exp_blank(k, exp_data));
    check_eq("frame_done", frame_done, (k > 0 && (k % (4 * SLOT)) == 0));
    check_eq("data_out", data_out, exp_data);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_data_out", data_out, 16'h0000);
    check_eq("rst_anode_sel", anode_sel, 2'd0);
    check_eq("rst_blank", blank, 1'b1);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_load_ready", load_ready, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; k = 0; exp_data = 16'h0000;
    reset_n = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    check_eq("k0_blank", blank, 1'b1);

    // Free-running scan, then a mid-frame load.
    repeat (55) step_chk();
    load_data = 16'h12AB; load_valid = 1'b1;
    step_chk();
    check_eq("ready_after_accept", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (4) step_chk();
    load_data = 16'hFFFF; load_valid = 1'b1;
    repeat (19) step_chk();
    exp_data = 16'h12AB;
    step_chk();
    check_eq("ready_on_commit", load_ready, 1'b0);
    step_chk();
    check_eq("ready_after_commit", load_ready, 1'b1);
    step_chk();
    check_eq("ready_after_held_accept", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (37) step_chk();
    exp_data = 16'hFFFF;
    step_chk();
    step_chk();
    check_eq("ready_after_commit2", load_ready, 1'b1);

    // Load presented on the frame_done cycle itself.
    repeat (39) step_chk();
    check_eq("ready_on_fd_cycle", load_ready, 1'b1);
    load_data = 16'hBEEF; load_valid = 1'b1;
    step_chk();
    check_eq("ready_fd_accept", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (38) step_chk();
    exp_data = 16'hBEEF;
    step_chk();

    // Leave a load pending, then reset while digit 2 is selected.
    repeat (5) step_chk();
    load_data = 16'h3333; load_valid = 1'b1;
    step_chk();
    check_eq("ready_pending_3333", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (19) step_chk();
    check_eq("anode_before_reset", anode_sel, 2'd2);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    exp_data = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;

    // Discarded pending value must not commit at the first boundary.
    repeat (40) step_chk();
    load_data = 16'h00A5; load_valid = 1'b1;
    step_chk();
    check_eq("ready_accept_00a5", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (38) step_chk();
    exp_data = 16'h00A5;
    repeat (46) step_chk();
    load_data = 16'h0000; load_valid = 1'b1;
    step_chk();
    check_eq("ready_accept_0000", load_ready, 1'b0);
    load_valid = 1'b0;
    repeat (33) step_chk();
    exp_data = 16'h0000;
    repeat (41) step_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
